// File: rtl/uc_sequencer.sv
// rtl/uc_sequencer.sv - control sequencer for the 16-bit accumulator CPU
// Optional build macro: UC_HALT_EN (HLT enters a sticky HALT state; otherwise HLT is a NOP)
module uc_sequencer #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              carry,
  input  logic [15:0]       mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  output logic              mem_we,
  output logic [2:0]        sel_UAL,
  output logic              load_R1,
  output logic              load_ACCU,
  output logic              load_carry,
  output logic              init_carry,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  localparam logic [2:0] OP_NOR = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_STA = 3'b011;
  localparam logic [2:0] OP_JCC = 3'b100;
  localparam logic [2:0] OP_JMP = 3'b101;
  localparam logic [2:0] OP_NOP = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_OPREAD,
    S_LOADR1,
    S_ALU,
    S_STORE
`ifdef UC_HALT_EN
    , S_HALT
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [2:0]        ir_op_q, ir_op_d;
  logic [ADDR_W-1:0] ir_addr_q, ir_addr_d;

  // Raw strobes before clock-enable / reset gating
  logic en_raw, we_raw, r1_raw, acc_raw, lc_raw, ic_raw;
  logic active;

  // Opcode bits between the address field and bit 13 carry no meaning here
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata;

  // Strobes only fire while enabled and out of reset, so an aborting reset kills a pending write
  assign active = ce & rst;

  // State, program counter and instruction register; advance only on clock enable
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      pc_q      <= '0;
      ir_op_q   <= '0;
      ir_addr_q <= '0;
    end else if (ce) begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_op_q   <= ir_op_d;
      ir_addr_q <= ir_addr_d;
    end
  end

  // Next-state, instruction decode and datapath control
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_op_d   = ir_op_q;
    ir_addr_d = ir_addr_q;
    en_raw    = 1'b0;
    we_raw    = 1'b0;
    r1_raw    = 1'b0;
    acc_raw   = 1'b0;
    lc_raw    = 1'b0;
    ic_raw    = 1'b0;
    mem_addr  = pc_q;
    sel_UAL   = 3'b000;
    unique case (state_q)
      S_FETCH: begin
        en_raw  = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        ir_op_d   = mem_rdata[15:13];
        ir_addr_d = mem_rdata[ADDR_W-1:0];
        pc_d      = pc_q + ADDR_W'(1);
        state_d   = S_FETCH;
        unique case (mem_rdata[15:13])
          OP_NOR, OP_ADD, OP_SUB: state_d = S_OPREAD;
          OP_STA:                 state_d = S_STORE;
          OP_JCC: begin
            // Taken when carry is clear; a fall-through consumes the carry
            if (!carry) pc_d = mem_rdata[ADDR_W-1:0];
            else        ic_raw = 1'b1;
          end
          OP_JMP: pc_d = mem_rdata[ADDR_W-1:0];
          OP_NOP: state_d = S_FETCH;
          OP_HLT: begin
`ifdef UC_HALT_EN
            state_d = S_HALT;
`else
            state_d = S_FETCH;
`endif
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_OPREAD: begin
        mem_addr = ir_addr_q;
        en_raw   = 1'b1;
        state_d  = S_LOADR1;
      end
      S_LOADR1: begin
        r1_raw  = 1'b1;
        state_d = S_ALU;
      end
      S_ALU: begin
        acc_raw = 1'b1;
        state_d = S_FETCH;
        unique case (ir_op_q)
          OP_ADD: begin
            sel_UAL = 3'b010;
            lc_raw  = 1'b1;
          end
          OP_SUB: begin
            sel_UAL = 3'b011;
            lc_raw  = 1'b1;
          end
          default: sel_UAL = 3'b000;
        endcase
      end
      S_STORE: begin
        mem_addr = ir_addr_q;
        we_raw   = 1'b1;
        state_d  = S_FETCH;
      end
`ifdef UC_HALT_EN
      S_HALT: state_d = S_HALT;
`endif
      default: state_d = S_FETCH;
    endcase
  end

  assign mem_en     = en_raw  & active;
  assign mem_we     = we_raw  & active;
  assign load_R1    = r1_raw  & active;
  assign load_ACCU  = acc_raw & active;
  assign load_carry = lc_raw  & active;
  assign init_carry = ic_raw  & active;
  assign pc         = pc_q;

`ifdef UC_HALT_EN
  assign halted = (state_q == S_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: doc/uc_sequencer.md
# uc_sequencer

Control sequencer for the 16-bit accumulator CPU. It fetches and decodes instruction words from a synchronous single-port memory and drives the datapath strobes: `sel_UAL`, `load_R1`, `load_ACCU`, `load_carry` and `init_carry`. It takes the datapath `carry` flag back to resolve conditional jumps. `mem_rdata` also feeds the datapath `data_in`, and the datapath `data_out` (ACCU) feeds the memory write data. Both of those connections are made outside this block.

## Interface
Parameters:
- `ADDR_W`, 8: program counter and memory address width. Legal range 1..13.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `ce`  in  1  clock enable; the sequencer advances only when `ce`=1.
- `carry`  in  1  datapath carry flag.
- `mem_rdata`  in  16  memory read data, valid the cycle after a read is issued.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_en`  out  1  memory read strobe.
- `mem_we`  out  1  memory write strobe; the memory writes ACCU.
- `sel_UAL`  out  3  ALU operation select: 000 NOR, 010 ADD, 011 SUB.
- `load_R1`, `load_ACCU`, `load_carry`, `init_carry`  out  1 each  datapath strobes.
- `pc`  out  ADDR_W  current program counter.
- `halted`  out  1  high while in HALT.

## Operation
- Instruction word: opcode in bits [15:13], operand address in bits [ADDR_W-1:0]. Unused bits are ignored.
- Opcodes:
  - 000 NOR, 001 ADD, 010 SUB: ACCU <= op(ACCU, M[a]).
  - 011 STA: M[a] <= ACCU.
  - 100 JCC: if `carry`=0, PC <= a; else fall through and clear carry.
  - 101 JMP: PC <= a.
  - 110 NOP.
  - 111 HLT: see Configuration.
- States: FETCH, DECODE, OPREAD, LOADR1, ALU, STORE, HALT.
- FETCH: `mem_addr`=PC, `mem_en`=1. Next state DECODE.
- DECODE: IR <= `mem_rdata`; PC <= PC+1, except JMP/taken JCC, which load PC <= a instead. Next state by opcode:
  - ALU ops -> OPREAD.
  - STA -> STORE.
  - JCC/JMP/NOP -> FETCH.
  - HLT -> HALT.
- JCC with `carry`=1: `init_carry`=1 during DECODE.
- OPREAD: `mem_addr`=IR[a], `mem_en`=1. Next state LOADR1.
- LOADR1: `load_R1`=1, so R1 captures `mem_rdata`. Next state ALU.
- ALU: `sel_UAL` per opcode, `load_ACCU`=1. `load_carry`=1 for ADD/SUB only; NOR leaves carry unchanged. Next state FETCH.
- STORE: `mem_addr`=IR[a], `mem_we`=1. Next state FETCH.
- `sel_UAL` is 000 in every state other than ALU.
- PC wraps modulo 2^ADDR_W: PC = 2^ADDR_W-1 increments to 0.
- `mem_addr` is PC in all states except OPREAD and STORE, where it is IR[a].

## Timing
- Reset (`rst`=0) values:
  - State FETCH, PC=0, IR=0.
  - `mem_addr`=0, `pc`=0, `sel_UAL`=000, `halted`=0.
  - All strobes 0: `mem_en`, `mem_we`, `load_*`, `init_carry`.
- Reset assertion mid-instruction aborts the instruction immediately. No partial write completes after `rst` falls.
- First fetch occurs on the first `ce`=1 cycle after `rst` rises.
- Cycles per instruction with `ce` held high:
  - ALU ops: 5 (FETCH, DECODE, OPREAD, LOADR1, ALU).
  - STA: 3.
  - JCC/JMP/NOP: 2.
- `ce`=0:
  - State, PC and IR hold.
  - All strobes are forced to 0; `mem_addr` and `sel_UAL` hold.
  - The memory must hold `mem_rdata` while `mem_en`=0, so DECODE and LOADR1 resume correctly after a stall of any length.
- All strobes are single-cycle, combinational from state, and gated by `ce`.
- JCC samples `carry` in DECODE. A carry produced by the immediately preceding ADD/SUB is already registered at that point.

## Configuration
- `UC_HALT_EN` defined:
  - HLT enters HALT and `halted`=1.
  - HALT drives no strobes; `mem_addr`=PC, which already points past HLT.
  - HALT is left only by reset.
- `UC_HALT_EN` undefined: opcode 111 executes as NOP, the HALT state is not built, and `halted` is tied to 0.

## Test plan
- Reset, then release with `ce`=1 -> first cycle has `mem_en`=1, `mem_addr`=0. `pc`=1 after DECODE.
- M[0]=ADD 0x10 (0x2010), M[0x10]=0x0005:
  - Cycle 3: `mem_addr`=0x10.
  - Cycle 4: `load_R1`.
  - Cycle 5: `sel_UAL`=010 with `load_ACCU`=`load_carry`=1.
  - Cycle 6: FETCH at `mem_addr`=1.
- JCC 0x40 (0x8040):
  - With `carry`=0 -> next FETCH `mem_addr`=0x40.
  - With `carry`=1 -> `init_carry` pulses in DECODE and next `mem_addr`=PC+1.
- STA 0x20 (0x6020) -> cycle 3 has `mem_we`=1 and `mem_addr`=0x20; `mem_en`=0 in that cycle.
- JMP 0xFF, then NOP at 0xFF (ADDR_W=8) -> PC wraps and the next fetch is `mem_addr`=0.
- Drop `ce` for 3 cycles inside LOADR1 -> no strobes during the stall. `load_R1` is asserted exactly once after `ce` returns.
- With `UC_HALT_EN`: HLT (0xE000) -> `halted`=1 and no strobes for 20 cycles. Pulsing `rst` low returns `pc` and `halted` to 0.
